// File: rtl/axil_cmd_master_if.sv
// ---------------------------------------------------------------------------
// axil_cmd_master_if
// AXI4-Lite bus bundle used between the command master and a slave.
//   aw*  : write address channel      w* : write data channel
//   b*   : write response channel     ar*: read address channel
//   r*   : read data channel
// Modports: master (drives valids / bready / rready), slave (the opposite).
// ---------------------------------------------------------------------------
interface axil_cmd_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) ();
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
// Turns a simple command stream (one command = one single-beat read or write)
// into AXI4-Lite transactions and returns the B/R response on a response
// stream. One transaction outstanding at a time.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   i_cmd_addr/data/strb     command payload (data/strb only used for writes)
//   i_cmd_write              1 = write, 0 = read
//   i_cmd_valid/o_cmd_ready  command handshake
//   o_rsp_data/resp/write    response payload (data is 0 for writes)
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_busy                   high whenever the FSM is not idle
//   m_axil                   AXI4-Lite master bus
// Every output is either a register or a decode of registered state, so there
// is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module axil_cmd_master #(
   parameter int         DATA_WIDTH = 32,
   parameter int         ADDR_WIDTH = 16,
   parameter int         STRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [2:0] PROT       = 3'b000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_cmd_data,
   input  logic [STRB_WIDTH-1:0] i_cmd_strb,
   input  logic                  i_cmd_write,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic [1:0]            o_rsp_resp,
   output logic                  o_rsp_write,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic                  o_busy,
   axil_cmd_master_if.master     m_axil
);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RSP
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [STRB_WIDTH-1:0] r_strb;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic [1:0]            r_rsp_resp;
   logic                  r_rsp_write;

   logic w_cmd_fire;
   logic w_awvalid;
   logic w_wvalid;
   logic w_aw_fire;
   logic w_w_fire;

   // Each write channel's valid stays up only until its own handshake; the
   // done flags remember which half has completed.
   assign w_cmd_fire = (r_state == IDLE) && i_cmd_valid;
   assign w_awvalid  = (r_state == WR_ADDR_DATA) && !r_aw_done;
   assign w_wvalid   = (r_state == WR_ADDR_DATA) && !r_w_done;
   assign w_aw_fire  = w_awvalid && m_axil.awready;
   assign w_w_fire   = w_wvalid && m_axil.wready;

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_cmd_valid) begin
               w_state_next = i_cmd_write ? WR_ADDR_DATA : RD_ADDR;
            end
         end
         WR_ADDR_DATA: begin
            if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
               w_state_next = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axil.bvalid) begin
               w_state_next = RSP;
            end
         end
         RD_ADDR: begin
            if (m_axil.arready) begin
               w_state_next = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axil.rvalid) begin
               w_state_next = RSP;
            end
         end
         RSP: begin
            if (i_rsp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_data      <= '0;
         r_strb      <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_resp  <= 2'b00;
         r_rsp_write <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (w_cmd_fire) begin
            r_addr    <= i_cmd_addr;
            r_data    <= i_cmd_data;
            r_strb    <= i_cmd_strb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end

         if (w_aw_fire) begin
            r_aw_done <= 1'b1;
         end
         if (w_w_fire) begin
            r_w_done <= 1'b1;
         end

         if ((r_state == WR_RESP) && m_axil.bvalid) begin
            r_rsp_data  <= '0;
            r_rsp_resp  <= m_axil.bresp;
            r_rsp_write <= 1'b1;
         end

         if ((r_state == RD_DATA) && m_axil.rvalid) begin
            r_rsp_data  <= m_axil.rdata;
            r_rsp_resp  <= m_axil.rresp;
            r_rsp_write <= 1'b0;
         end
      end
   end

   // Outputs decoded from registered state
   assign o_cmd_ready = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_rsp_valid = (r_state == RSP);
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_resp  = r_rsp_resp;
   assign o_rsp_write = r_rsp_write;

   assign m_axil.awaddr  = r_addr;
   assign m_axil.awprot  = PROT;
   assign m_axil.awvalid = w_awvalid;
   assign m_axil.wdata   = r_data;
   assign m_axil.wstrb   = r_strb;
   assign m_axil.wvalid  = w_wvalid;
   // Only entered once both AW and W have handshaken.
   assign m_axil.bready  = (r_state == WR_RESP);
   assign m_axil.araddr  = r_addr;
   assign m_axil.arprot  = PROT;
   assign m_axil.arvalid = (r_state == RD_ADDR);
   assign m_axil.rready  = (r_state == RD_DATA);

endmodule

// File: tb/tb_axil_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axil_cmd_master
// Directed bench for axil_cmd_master with a small AXI-Lite RAM slave model
// (configurable AW/W ready delay and forced RRESP). Expected responses are
// queued when a command is issued; a monitor pops and compares them at each
// response handshake.
// ---------------------------------------------------------------------------
module tb_axil_cmd_master;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_data  = '0;
   logic [SW-1:0] cmd_strb  = '0;
   logic          cmd_write = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_resp;
   logic          rsp_write;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          busy;

   axil_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_cmd_addr (cmd_addr),
      .i_cmd_data (cmd_data),
      .i_cmd_strb (cmd_strb),
      .i_cmd_write(cmd_write),
      .i_cmd_valid(cmd_valid),
      .o_cmd_ready(cmd_ready),
      .o_rsp_data (rsp_data),
      .o_rsp_resp (rsp_resp),
      .o_rsp_write(rsp_write),
      .o_rsp_valid(rsp_valid),
      .i_rsp_ready(rsp_ready),
      .o_busy     (busy),
      .m_axil     (bus.master)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          write;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_expected = 0;
   int   rsp_count  = 0;

   // ---------------- slave model ----------------
   logic [DW-1:0] ram [0:63];
   int            aw_delay    = 0;
   int            w_delay     = 0;
   logic [1:0]    rresp_force = 2'b00;
   int            aw_cnt;
   int            w_cnt;
   logic          aw_got;
   logic          w_got;
   logic [AW-1:0] aw_addr_l;
   logic [DW-1:0] w_data_l;
   logic [SW-1:0] w_strb_l;
   logic          s_bvalid;
   logic          s_rvalid;
   logic [1:0]    s_rresp;
   logic [DW-1:0] s_rdata;

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
   end

   wire          s_aw_fire = bus.awvalid & bus.awready;
   wire          s_w_fire  = bus.wvalid & bus.wready;
   wire          s_ar_fire = bus.arvalid & bus.arready;
   wire          have_aw   = aw_got | s_aw_fire;
   wire          have_w    = w_got | s_w_fire;
   wire [AW-1:0] s_waddr   = aw_got ? aw_addr_l : bus.awaddr;
   wire [DW-1:0] s_wdata   = w_got ? w_data_l : bus.wdata;
   wire [SW-1:0] s_wstrb   = w_got ? w_strb_l : bus.wstrb;

   // Ready rises once valid has waited aw_delay/w_delay cycles; a delay of 0
   // means ready is already high before valid.
   assign bus.awready = (aw_cnt >= aw_delay);
   assign bus.wready  = (w_cnt >= w_delay);
   assign bus.arready = 1'b1;
   assign bus.bvalid  = s_bvalid;
   assign bus.bresp   = 2'b00;
   assign bus.rvalid  = s_rvalid;
   assign bus.rresp   = s_rresp;
   assign bus.rdata   = s_rdata;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_cnt   <= 0;
         w_cnt    <= 0;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         s_bvalid <= 1'b0;
         s_rvalid <= 1'b0;
         s_rresp  <= 2'b00;
         s_rdata  <= '0;
      end else begin
         if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
         else if (s_aw_fire)               aw_cnt <= 0;
         if (bus.wvalid && !bus.wready)    w_cnt <= w_cnt + 1;
         else if (s_w_fire)                w_cnt <= 0;

         if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
         if (have_aw && have_w) begin
            for (int b = 0; b < SW; b++)
               if (s_wstrb[b]) ram[s_waddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            s_bvalid <= 1'b1;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end else begin
            if (s_aw_fire) begin
               aw_got    <= 1'b1;
               aw_addr_l <= bus.awaddr;
            end
            if (s_w_fire) begin
               w_got    <= 1'b1;
               w_data_l <= bus.wdata;
               w_strb_l <= bus.wstrb;
            end
         end

         if (s_ar_fire) begin
            s_rvalid <= 1'b1;
            s_rdata  <= ram[bus.araddr[7:2]];
            s_rresp  <= rresp_force;
         end else if (s_rvalid && bus.rready) begin
            s_rvalid <= 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_data;
   int            aw_cycles;
   int            w_cycles;
   int            b_hs;
   logic          aw_seen;
   logic          w_seen;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.awvalid) begin
            aw_cycles++;
            check("awaddr_stable", bus.awaddr, cur_addr);
            if (bus.awready) aw_seen = 1'b1;
         end
         if (bus.wvalid) begin
            w_cycles++;
            check("wdata_stable", bus.wdata, cur_data);
            if (bus.wready) w_seen = 1'b1;
         end
         if (bus.bready) check("bready_after_aw_w", {aw_seen, w_seen}, 2'b11);
         if (bus.bvalid && bus.bready) b_hs++;

         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_resp", rsp_resp, e.resp);
               check("rsp_write", rsp_write, e.write);
            end
            rsp_count++;
            $display("rsp #%0d: write=%0b data=0x%08h resp=%0d", rsp_count, rsp_write, rsp_data, rsp_resp);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic w, input logic [DW-1:0] ed, input logic [1:0] er, input bit push);
      int bound;
      @(posedge clk);
      #1;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_strb  = s;
      cmd_write = w;
      cmd_valid = 1'b1;
      bound     = 0;
      @(negedge clk);
      while (!cmd_ready) begin
         bound++;
         if (bound > 50) begin
            check("cmd_accept_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cur_addr  = a;
      cur_data  = d;
      aw_cycles = 0;
      w_cycles  = 0;
      b_hs      = 0;
      aw_seen   = 1'b0;
      w_seen    = 1'b0;
      if (push) begin
         exp_q.push_back('{data: ed, resp: er, write: w});
         n_expected++;
      end
   endtask

   task automatic wait_rsp();
      int bound;
      bound = 0;
      while (rsp_count < n_expected && bound < 100) begin
         @(negedge clk);
         bound++;
      end
      check("rsp_timeout", (rsp_count >= n_expected), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cur_addr = '0;
      cur_data = '0;
      aw_seen  = 1'b0;
      w_seen   = 1'b0;

      // Reset state
      #12;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_fields", {rsp_data, rsp_resp, rsp_write}, 0);
      check("rst_axi_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
      check("rst_axi_payload", {bus.awaddr, bus.wdata, bus.wstrb}, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: minimum-latency write
      issue(16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 2'b00, 1'b1);
      @(negedge clk); // T1
      check("t1_aw_w_valid", {bus.awvalid, bus.wvalid, busy}, 3'b111);
      @(negedge clk); // T2
      check("t1_bready_T2", {bus.bready, rsp_valid, bus.awvalid, bus.wvalid}, 4'b1000);
      @(negedge clk); // T3
      check("t1_rsp_valid_T3", {rsp_valid, cmd_ready}, 2'b10);
      @(negedge clk); // T4
      check("t1_cmd_ready_T4", {rsp_valid, cmd_ready}, 2'b01);
      wait_rsp();
      check("t1_aw_cycles", aw_cycles, 1);
      check("t1_w_cycles", w_cycles, 1);

      // 2: read back
      issue(16'h0010, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 2'b00, 1'b1);
      wait_rsp();

      // 3: awready delayed 3 cycles, wready immediate
      aw_delay = 3;
      issue(16'h0014, 32'h01020304, 4'hF, 1'b1, 32'h0, 2'b00, 1'b1);
      wait_rsp();
      check("t3_aw_cycles", aw_cycles, 4);
      check("t3_w_cycles", w_cycles, 1);
      check("t3_b_handshakes", b_hs, 1);
      aw_delay = 0;

      // 4: SLVERR read with response back-pressure
      issue(16'h0030, 32'h12345678, 4'hF, 1'b1, 32'h0, 2'b00, 1'b1);
      wait_rsp();
      rsp_ready   = 1'b0;
      rresp_force = 2'b10;
      issue(16'h0030, 32'h0, 4'h0, 1'b0, 32'h12345678, 2'b10, 1'b1);
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("t4_hold", {rsp_valid, cmd_ready, rsp_data, rsp_resp}, {1'b1, 1'b0, 32'h12345678, 2'b10});
         if (i < 4) @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_rsp();
      rresp_force = 2'b00;
      @(negedge clk);
      check("t4_idle", {cmd_ready, busy}, 2'b10);

      // 5: partial write
      issue(16'h0020, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 2'b00, 1'b1);
      wait_rsp();
      issue(16'h0020, 32'hAAAA5555, 4'b0011, 1'b1, 32'h0, 2'b00, 1'b1);
      wait_rsp();
      issue(16'h0020, 32'h0, 4'h0, 1'b0, 32'hFFFF5555, 2'b00, 1'b1);
      wait_rsp();

      // 6: reset while AW pending and W already done
      aw_delay = 3;
      issue(16'h0050, 32'h55555555, 4'hF, 1'b1, 32'h0, 2'b00, 1'b0);
      @(negedge clk); // T1
      @(negedge clk); // T2
      check("t6_pre_reset", {bus.awvalid, bus.wvalid, busy}, 3'b101);
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_reset", {bus.awvalid, busy, cmd_ready}, 3'b001);
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      aw_delay = 0;
      issue(16'h0050, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 2'b00, 1'b1);
      wait_rsp();
      issue(16'h0050, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 2'b00, 1'b1);
      wait_rsp();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
